branch_predict_unit: RTL and testbench

BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

---
 rtl/branch_predict_unit.sv | 117 +++++++++++
 tb/tb_branch_predict_unit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_predict_unit.sv
// Branch resolution plus 2-bit-counter BHT prediction and branch/mispredict statistics.
// Latency: prediction is combinational from f_pc; resolution results are registered one cycle after issue.
// Backpressure: none; an issue is accepted every cycle that ex_valid is high and flush is low.
module branch_predict_unit #(
   parameter int XLEN      = 32,
   parameter int BHT_DEPTH = 64,
   parameter int CNT_W     = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [XLEN-1:0]  f_pc,
   output logic             f_pred_taken,
   input  logic             ex_valid,
   input  logic [XLEN-1:0]  ex_pc,
   input  logic [XLEN-1:0]  rsdata_a,
   input  logic [XLEN-1:0]  rsdata_b,
   input  logic [XLEN-1:0]  imm,
   input  logic [2:0]       ctrl,
   input  logic             jump_en,
   input  logic             ex_pred_taken,
   input  logic             flush,
   output logic             res_valid,
   output logic [XLEN-1:0]  res_pc,
   output logic             res_taken,
   output logic             mispredict,
   output logic [CNT_W-1:0] br_cnt,
   output logic [CNT_W-1:0] mp_cnt
);

   localparam int IDX_W = $clog2(BHT_DEPTH);

   localparam logic [2:0] CTRL_EQ  = 3'b000;
   localparam logic [2:0] CTRL_NE  = 3'b001;
   localparam logic [2:0] CTRL_LT  = 3'b100;
   localparam logic [2:0] CTRL_GE  = 3'b101;
   localparam logic [2:0] CTRL_LTU = 3'b110;
   localparam logic [2:0] CTRL_GEU = 3'b111;

   logic [1:0]       bht [BHT_DEPTH];
   logic [IDX_W-1:0] f_idx;
   logic [IDX_W-1:0] ex_idx;
   logic             issue;
   logic             cond_true;
   logic             taken;
   logic             mp_now;
   logic [XLEN-1:0]  target;
   logic [1:0]       ex_cnt;
   logic [1:0]       cnt_nxt;
   logic             unused_pc_bits;

   // Word-aligned PCs: drop the two byte-offset bits before indexing.
   assign f_idx  = f_pc[IDX_W+1:2];
   assign ex_idx = ex_pc[IDX_W+1:2];
   assign unused_pc_bits = ^{f_pc[XLEN-1:IDX_W+2], f_pc[1:0]};

   assign f_pred_taken = bht[f_idx][1];

   assign issue = ex_valid & ~flush;

   always_comb begin
      cond_true = 1'b0;
      case (ctrl)
         CTRL_EQ:  cond_true = (rsdata_a == rsdata_b);
         CTRL_NE:  cond_true = (rsdata_a != rsdata_b);
         CTRL_LT:  cond_true = ($signed(rsdata_a) <  $signed(rsdata_b));
         CTRL_GE:  cond_true = ($signed(rsdata_a) >= $signed(rsdata_b));
         CTRL_LTU: cond_true = (rsdata_a <  rsdata_b);
         CTRL_GEU: cond_true = (rsdata_a >= rsdata_b);
         default:  cond_true = 1'b0;
      endcase
   end

   assign taken  = jump_en & cond_true;
   assign mp_now = jump_en & (taken ^ ex_pred_taken);
   assign target = taken ? (ex_pc + imm) : (ex_pc + XLEN'(4));

   // Saturating 2-bit counter step.
   always_comb begin
      ex_cnt  = bht[ex_idx];
      cnt_nxt = ex_cnt;
      if (taken) begin
         if (ex_cnt != 2'b11) cnt_nxt = ex_cnt + 2'b01;
      end else begin
         if (ex_cnt != 2'b00) cnt_nxt = ex_cnt - 2'b01;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < BHT_DEPTH; i++) begin
            bht[i] <= 2'b01;
         end
         res_valid  <= 1'b0;
         res_pc     <= '0;
         res_taken  <= 1'b0;
         mispredict <= 1'b0;
         br_cnt     <= '0;
         mp_cnt     <= '0;
      end else begin
         res_valid <= issue;
         if (issue) begin
            res_pc     <= target;
            res_taken  <= taken;
            mispredict <= mp_now;
            if (jump_en) begin
               bht[ex_idx] <= cnt_nxt;
               br_cnt      <= br_cnt + CNT_W'(1);
               mp_cnt      <= mp_cnt + CNT_W'(mp_now);
            end
         end else if (!flush) begin
            // A flushed op leaves every register but res_valid alone.
            mispredict <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed-vector bench for branch_predict_unit with a 4-bit statistics counter width.
module tb_branch_predict_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] f_pc;
   logic        f_pred_taken;
   logic        ex_valid;
   logic [31:0] ex_pc;
   logic [31:0] rsdata_a;
   logic [31:0] rsdata_b;
   logic [31:0] imm;
   logic [2:0]  ctrl;
   logic        jump_en;
   logic        ex_pred_taken;
   logic        flush;
   logic        res_valid;
   logic [31:0] res_pc;
   logic        res_taken;
   logic        mispredict;
   logic [3:0]  br_cnt;
   logic [3:0]  mp_cnt;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   branch_predict_unit #(.XLEN(32), .BHT_DEPTH(64), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .f_pc(f_pc), .f_pred_taken(f_pred_taken),
      .ex_valid(ex_valid), .ex_pc(ex_pc), .rsdata_a(rsdata_a), .rsdata_b(rsdata_b),
      .imm(imm), .ctrl(ctrl), .jump_en(jump_en), .ex_pred_taken(ex_pred_taken),
      .flush(flush), .res_valid(res_valid), .res_pc(res_pc), .res_taken(res_taken),
      .mispredict(mispredict), .br_cnt(br_cnt), .mp_cnt(mp_cnt)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] im, input logic [2:0] c, input logic je, input logic pr);
      ex_valid = 1'b1; ex_pc = pc; rsdata_a = a; rsdata_b = b;
      imm = im; ctrl = c; jump_en = je; ex_pred_taken = pr;
   endtask

   task automatic do_op(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] im, input logic [2:0] c, input logic je, input logic pr);
      set_op(pc, a, b, im, c, je, pr);
      tick();
      ex_valid = 1'b0;
   endtask

   task automatic pred_at(input string tag, input logic [31:0] pc, input logic exp);
      f_pc = pc;
      #1;
      check(tag, {63'd0, f_pred_taken}, {63'd0, exp});
   endtask

   // ctrl, a, b, expected taken (ex_pc 0x204, imm 8, predicted not-taken)
   typedef struct {
      logic [2:0]  c;
      logic [31:0] a;
      logic [31:0] b;
      logic        tk;
   } vec_t;

   vec_t tbl [7] = '{
      '{3'b000, 32'd5,        32'd5,        1'b1},
      '{3'b001, 32'd5,        32'd5,        1'b0},
      '{3'b101, 32'hFFFFFFFF, 32'd1,        1'b0},
      '{3'b111, 32'hFFFFFFFF, 32'd1,        1'b1},
      '{3'b010, 32'd5,        32'd5,        1'b0},
      '{3'b011, 32'd5,        32'd5,        1'b0},
      '{3'b100, 32'd1,        32'hFFFFFFFF, 1'b0}
   };

   initial begin
      rst = 1'b1; f_pc = '0; ex_valid = 1'b0; ex_pc = '0; rsdata_a = '0; rsdata_b = '0;
      imm = '0; ctrl = '0; jump_en = 1'b0; ex_pred_taken = 1'b0; flush = 1'b0;
      tick();
      tick();
      rst = 1'b0;

      check("rst_res_valid", {63'd0, res_valid}, 64'd0);
      check("rst_res_pc", {32'd0, res_pc}, 64'd0);
      check("rst_res_taken", {63'd0, res_taken}, 64'd0);
      check("rst_mispredict", {63'd0, mispredict}, 64'd0);
      check("rst_br_cnt", {60'd0, br_cnt}, 64'd0);
      check("rst_mp_cnt", {60'd0, mp_cnt}, 64'd0);
      pred_at("rst_pred_100", 32'h100, 1'b0);

      // BLT signed: -1 < 1 -> taken, predicted not-taken
      do_op(32'h100, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFF0, 3'b100, 1'b1, 1'b0);
      check("blt_valid", {63'd0, res_valid}, 64'd1);
      check("blt_pc", {32'd0, res_pc}, 64'hF0);
      check("blt_taken", {63'd0, res_taken}, 64'd1);
      check("blt_mp", {63'd0, mispredict}, 64'd1);
      check("blt_br_cnt", {60'd0, br_cnt}, 64'd1);
      check("blt_mp_cnt", {60'd0, mp_cnt}, 64'd1);
      pred_at("blt_pred_idx0", 32'h100, 1'b1);

      tick();
      check("idle_valid", {63'd0, res_valid}, 64'd0);
      check("idle_pc_hold", {32'd0, res_pc}, 64'hF0);
      check("idle_taken_hold", {63'd0, res_taken}, 64'd1);
      check("idle_mp_clear", {63'd0, mispredict}, 64'd0);

      // BLTU: 0xFFFFFFFF < 1 unsigned is false
      do_op(32'h100, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFF0, 3'b110, 1'b1, 1'b0);
      check("bltu_pc", {32'd0, res_pc}, 64'h104);
      check("bltu_taken", {63'd0, res_taken}, 64'd0);
      check("bltu_mp", {63'd0, mispredict}, 64'd0);
      check("bltu_mp_cnt", {60'd0, mp_cnt}, 64'd1);

      foreach (tbl[k]) begin
         do_op(32'h204, tbl[k].a, tbl[k].b, 32'd8, tbl[k].c, 1'b1, 1'b0);
         check($sformatf("cond%0d_taken", k), {63'd0, res_taken}, {63'd0, tbl[k].tk});
         check($sformatf("cond%0d_pc", k), {32'd0, res_pc}, tbl[k].tk ? 64'h20C : 64'h208);
         check($sformatf("cond%0d_mp", k), {63'd0, mispredict}, {63'd0, tbl[k].tk});
      end
      check("tbl_br_cnt", {60'd0, br_cnt}, 64'd9);
      check("tbl_mp_cnt", {60'd0, mp_cnt}, 64'd3);

      // Training at 0x40: 01 -> 10 -> 11 -> 11 (sat) -> 10 -> 01
      do_op(32'h40, 32'd0, 32'd0, 32'd16, 3'b000, 1'b1, 1'b1);
      pred_at("train1_pred", 32'h40, 1'b1);
      do_op(32'h40, 32'd0, 32'd0, 32'd16, 3'b000, 1'b1, 1'b1);
      pred_at("train2_pred", 32'h40, 1'b1);
      do_op(32'h40, 32'd0, 32'd0, 32'd16, 3'b000, 1'b1, 1'b1);
      check("train3_mp", {63'd0, mispredict}, 64'd0);
      do_op(32'h40, 32'd0, 32'd0, 32'd16, 3'b001, 1'b1, 1'b1);
      check("train4_mp", {63'd0, mispredict}, 64'd1);
      pred_at("train4_pred", 32'h40, 1'b1);
      do_op(32'h40, 32'd0, 32'd0, 32'd16, 3'b001, 1'b1, 1'b1);
      pred_at("train5_pred", 32'h40, 1'b0);
      check("train_br_cnt", {60'd0, br_cnt}, 64'd14);
      check("train_mp_cnt", {60'd0, mp_cnt}, 64'd5);

      flush = 1'b1;
      do_op(32'h40, 32'd0, 32'd0, 32'd16, 3'b000, 1'b1, 1'b0);
      flush = 1'b0;
      check("flush_valid", {63'd0, res_valid}, 64'd0);
      check("flush_pc_hold", {32'd0, res_pc}, 64'h44);
      check("flush_br_cnt", {60'd0, br_cnt}, 64'd14);
      check("flush_mp_cnt", {60'd0, mp_cnt}, 64'd5);
      pred_at("flush_pred", 32'h40, 1'b0);

      // Non-branch at top of address space: fall-through wraps to 0
      do_op(32'hFFFFFFFC, 32'd7, 32'd7, 32'h100, 3'b000, 1'b0, 1'b0);
      check("nobr_valid", {63'd0, res_valid}, 64'd1);
      check("nobr_pc", {32'd0, res_pc}, 64'h0);
      check("nobr_taken", {63'd0, res_taken}, 64'd0);
      check("nobr_mp", {63'd0, mispredict}, 64'd0);
      check("nobr_br_cnt", {60'd0, br_cnt}, 64'd14);
      pred_at("nobr_pred", 32'hFFFFFFFC, 1'b0);

      // Collision at index 5: lookup sees 01 during the update, 10 afterwards
      set_op(32'h14, 32'd0, 32'd0, 32'd4, 3'b000, 1'b1, 1'b1);
      pred_at("coll_pred_old", 32'h14, 1'b0);
      tick();
      ex_valid = 1'b0;
      check("coll_pred_new", {63'd0, f_pred_taken}, 64'd1);
      check("coll_br_cnt", {60'd0, br_cnt}, 64'd15);

      do_op(32'h80, 32'd1, 32'd2, 32'd4, 3'b000, 1'b1, 1'b0);
      check("wrap_br_cnt0", {60'd0, br_cnt}, 64'd0);
      for (int k = 0; k < 15; k++) begin
         do_op(32'h80, 32'd1, 32'd2, 32'd4, 3'b000, 1'b1, 1'b0);
      end
      check("wrap_br_cnt16", {60'd0, br_cnt}, 64'd15);
      check("wrap_mp_cnt", {60'd0, mp_cnt}, 64'd5);

      // Issue coincident with reset is discarded
      rst = 1'b1;
      do_op(32'h80, 32'd0, 32'd0, 32'd4, 3'b000, 1'b1, 1'b0);
      rst = 1'b0;
      check("rstprio_valid", {63'd0, res_valid}, 64'd0);
      check("rstprio_br_cnt", {60'd0, br_cnt}, 64'd0);
      check("rstprio_mp_cnt", {60'd0, mp_cnt}, 64'd0);
      pred_at("rstprio_pred", 32'h14, 1'b0);

      // Reset the cycle after an issue clears the pending result
      do_op(32'h80, 32'd0, 32'd0, 32'd4, 3'b000, 1'b1, 1'b0);
      check("mid_pre_valid", {63'd0, res_valid}, 64'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_valid", {63'd0, res_valid}, 64'd0);
      check("mid_pc", {32'd0, res_pc}, 64'd0);
      check("mid_br_cnt", {60'd0, br_cnt}, 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
